// File: rtl/regfile_sb_pkg.sv
// Shared CPU package: register-file defaults, the zero-register index and
// helpers for locating a port's slice inside a packed multi-port bus.
package regfile_sb_pkg;

  localparam int unsigned RF_DATA_W = 32;
  localparam int unsigned RF_ADDR_W = 5;
  localparam int unsigned ZERO_IDX  = 0;

  function automatic int unsigned slice_lo(input int unsigned port, input int unsigned width);
    return port * width;
  endfunction

  function automatic int unsigned slice_hi(input int unsigned port, input int unsigned width);
    return (port + 1) * width - 1;
  endfunction

endpackage

// File: rtl/regfile_sb_bypass.sv
// One read port: same-cycle write-through bypass with highest-port priority,
// plus the pending (busy) flag that a same-cycle write clears.
module regfile_sb_bypass
  import regfile_sb_pkg::*;
#(
  parameter int unsigned DATA_W   = RF_DATA_W,
  parameter int unsigned ADDR_W   = RF_ADDR_W,
  parameter int unsigned WR_PORTS = 2
) (
  input  logic [ADDR_W-1:0]          rd_addr,
  input  logic [WR_PORTS-1:0]        wr_en,
  input  logic [WR_PORTS*ADDR_W-1:0] wr_addr,
  input  logic [WR_PORTS*DATA_W-1:0] wr_data,
  input  logic [DATA_W-1:0]          stored_data,
  input  logic                       pending,
  output logic [DATA_W-1:0]          rd_data,
  output logic                       rd_busy
);

  always_comb begin
    rd_data = stored_data;
    rd_busy = pending;
    // Ascending scan so the highest-numbered matching port is the last to assign
    for (int unsigned w = 0; w < WR_PORTS; w++) begin
      if (wr_en[w] && (wr_addr[slice_lo(w, ADDR_W) +: ADDR_W] == rd_addr)) begin
        rd_data = wr_data[slice_lo(w, DATA_W) +: DATA_W];
        rd_busy = 1'b0;
      end
    end
    if (rd_addr == ADDR_W'(ZERO_IDX)) begin
      rd_data = '0;
      rd_busy = 1'b0;
    end
  end

endmodule

// File: rtl/regfile_sb.sv
// Multi-port register file with write-through bypass and a per-register
// pending scoreboard; r0 is hardwired zero and never pending.
module regfile_sb
  import regfile_sb_pkg::*;
#(
  parameter int unsigned DATA_W   = RF_DATA_W,
  parameter int unsigned ADDR_W   = RF_ADDR_W,
  parameter int unsigned RD_PORTS = 2,
  parameter int unsigned WR_PORTS = 2
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [RD_PORTS*ADDR_W-1:0] rd_addr,
  output logic [RD_PORTS*DATA_W-1:0] rd_data,
  output logic [RD_PORTS-1:0]        rd_busy,
  input  logic [WR_PORTS-1:0]        wr_en,
  input  logic [WR_PORTS*ADDR_W-1:0] wr_addr,
  input  logic [WR_PORTS*DATA_W-1:0] wr_data,
  input  logic                       rsv_en,
  input  logic [ADDR_W-1:0]          rsv_addr,
  output logic                       stall,
  output logic [ADDR_W:0]            pending_cnt
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;
  localparam int unsigned CNT_W = ADDR_W + 1;

  logic [DATA_W-1:0] mem_q [DEPTH-1:1];
  logic [DATA_W-1:0] mem_d [DEPTH-1:1];
  logic [DEPTH-1:0]  pend_q, pend_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [WR_PORTS-1:0] we;
  logic                rsv_v;
  logic                clr_w;

  // Effective strobes: reset and index 0 suppress writes and reservations
  always_comb begin
    we = '0;
    for (int unsigned w = 0; w < WR_PORTS; w++) begin
      we[w] = wr_en[w] && !reset &&
              (wr_addr[slice_lo(w, ADDR_W) +: ADDR_W] != ADDR_W'(ZERO_IDX));
    end
    rsv_v = rsv_en && !reset && (rsv_addr != ADDR_W'(ZERO_IDX));
  end

  always_comb begin
    mem_d  = mem_q;
    pend_d = pend_q;
    cnt_d  = cnt_q;
    clr_w  = 1'b0;
    for (int unsigned w = 0; w < WR_PORTS; w++) begin
      if (we[w]) begin
        mem_d[wr_addr[slice_lo(w, ADDR_W) +: ADDR_W]]  = wr_data[slice_lo(w, DATA_W) +: DATA_W];
        pend_d[wr_addr[slice_lo(w, ADDR_W) +: ADDR_W]] = 1'b0;
      end
    end
    if (rsv_v) begin
      pend_d[rsv_addr] = 1'b1;
    end
    pend_d[ZERO_IDX] = 1'b0;

    if (rsv_v && !pend_q[rsv_addr]) begin
      cnt_d = cnt_d + CNT_W'(1);
    end
    // A clear counts once per index; a same-cycle reservation keeps the bit set
    for (int unsigned w = 0; w < WR_PORTS; w++) begin
      clr_w = we[w] && pend_q[wr_addr[slice_lo(w, ADDR_W) +: ADDR_W]] &&
              !(rsv_v && (rsv_addr == wr_addr[slice_lo(w, ADDR_W) +: ADDR_W]));
      for (int unsigned v = w + 1; v < WR_PORTS; v++) begin
        if (we[v] && (wr_addr[slice_lo(v, ADDR_W) +: ADDR_W] ==
                      wr_addr[slice_lo(w, ADDR_W) +: ADDR_W])) begin
          clr_w = 1'b0;
        end
      end
      if (clr_w) begin
        cnt_d = cnt_d - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 1; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      pend_q <= '0;
      cnt_q  <= '0;
    end else begin
      mem_q  <= mem_d;
      pend_q <= pend_d;
      cnt_q  <= cnt_d;
    end
  end

  for (genvar p = 0; p < RD_PORTS; p++) begin : g_rd
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] stored;
    logic              pend_bit;

    always_comb begin
      addr     = rd_addr[slice_hi(p, ADDR_W):slice_lo(p, ADDR_W)];
      stored   = (addr == ADDR_W'(ZERO_IDX)) ? '0 : mem_q[addr];
      pend_bit = pend_q[addr];
    end

    regfile_sb_bypass #(
      .DATA_W  (DATA_W),
      .ADDR_W  (ADDR_W),
      .WR_PORTS(WR_PORTS)
    ) u_bypass (
      .rd_addr    (addr),
      .wr_en      (we),
      .wr_addr    (wr_addr),
      .wr_data    (wr_data),
      .stored_data(stored),
      .pending    (pend_bit),
      .rd_data    (rd_data[slice_hi(p, DATA_W):slice_lo(p, DATA_W)]),
      .rd_busy    (rd_busy[p])
    );
  end

  assign stall       = |rd_busy;
  assign pending_cnt = cnt_q;

endmodule

// File: tb/tb_regfile_sb.sv
// Bench for regfile_sb: directed vector table, reset-mid-write sequence, then
// random traffic checked against an array-based reference model.
module tb_regfile_sb;

  logic        clock = 1'b0;
  logic        reset;
  logic [9:0]  rd_addr;
  logic [63:0] rd_data;
  logic [1:0]  rd_busy;
  logic [1:0]  wr_en;
  logic [9:0]  wr_addr;
  logic [63:0] wr_data;
  logic        rsv_en;
  logic [4:0]  rsv_addr;
  logic        stall;
  logic [5:0]  pending_cnt;

  regfile_sb dut (
    .clock      (clock),
    .reset      (reset),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .rd_busy    (rd_busy),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .rsv_en     (rsv_en),
    .rsv_addr   (rsv_addr),
    .stall      (stall),
    .pending_cnt(pending_cnt)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [1:0]  wen;
    logic [4:0]  wa0, wa1;
    logic [31:0] wd0, wd1;
    logic        rsv;
    logic [4:0]  ra;
    logic [4:0]  r0, r1;
    logic [31:0] e_d0, e_d1;
    logic        e_b0, e_b1;
    logic [5:0]  e_cnt;
  } vec_t;

  int n_cmp = 0;
  int n_err = 0;

  logic [31:0] m_reg [32];
  bit          m_pend [32];

  logic [31:0] a_d0, a_d1;
  logic        a_b0, a_b1, a_stall;
  logic [5:0]  a_cnt;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic m_reset();
    for (int i = 0; i < 32; i++) begin
      m_reg[i]  = '0;
      m_pend[i] = 1'b0;
    end
  endtask

  function automatic logic [31:0] m_read(input vec_t v, input logic [4:0] a);
    logic [31:0] r;
    if (a == 0) return '0;
    r = m_reg[a];
    if (v.wen[0] && v.wa0 == a) r = v.wd0;
    if (v.wen[1] && v.wa1 == a) r = v.wd1;
    return r;
  endfunction

  function automatic logic m_busy(input vec_t v, input logic [4:0] a);
    if (a == 0) return 1'b0;
    if ((v.wen[0] && v.wa0 == a) || (v.wen[1] && v.wa1 == a)) return 1'b0;
    return m_pend[a];
  endfunction

  function automatic logic [5:0] m_count();
    int c = 0;
    for (int i = 1; i < 32; i++) c += int'(m_pend[i]);
    return 6'(c);
  endfunction

  task automatic m_step(input vec_t v);
    if (v.wen[0] && v.wa0 != 0) begin m_reg[v.wa0] = v.wd0; m_pend[v.wa0] = 1'b0; end
    if (v.wen[1] && v.wa1 != 0) begin m_reg[v.wa1] = v.wd1; m_pend[v.wa1] = 1'b0; end
    if (v.rsv && v.ra != 0) m_pend[v.ra] = 1'b1;
  endtask

  // Called just after a falling edge; leaves the bench just after the next one
  task automatic do_cycle(input vec_t v);
    logic e_b0, e_b1;
    wr_en    = v.wen;
    wr_addr  = {v.wa1, v.wa0};
    wr_data  = {v.wd1, v.wd0};
    rsv_en   = v.rsv;
    rsv_addr = v.ra;
    rd_addr  = {v.r1, v.r0};
    #2;
    a_d0 = rd_data[31:0];  a_d1 = rd_data[63:32];
    a_b0 = rd_busy[0];     a_b1 = rd_busy[1];
    a_stall = stall;
    e_b0 = m_busy(v, v.r0);
    e_b1 = m_busy(v, v.r1);
    chk("model rd_data0", a_d0, m_read(v, v.r0));
    chk("model rd_data1", a_d1, m_read(v, v.r1));
    chk("model rd_busy0", 32'(a_b0), 32'(e_b0));
    chk("model rd_busy1", 32'(a_b1), 32'(e_b1));
    chk("model stall", 32'(a_stall), 32'(e_b0 | e_b1));
    @(posedge clock);
    m_step(v);
    #1;
    a_cnt = pending_cnt;
    chk("model pending_cnt", 32'(a_cnt), 32'(m_count()));
    @(negedge clock);
  endtask

  vec_t tbl [11];
  vec_t rv;

  initial begin
    reset = 1'b1;
    wr_en = '0; wr_addr = '0; wr_data = '0;
    rsv_en = 1'b0; rsv_addr = '0; rd_addr = {5'd3, 5'd7};
    m_reset();

    tbl[0]  = '{2'b01, 5'd7, 5'd0, 32'hDEADBEEF, 32'h0, 1'b0, 5'd0, 5'd7, 5'd0,
                32'hDEADBEEF, 32'h0, 1'b0, 1'b0, 6'd0};
    tbl[1]  = '{2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 1'b0, 5'd0, 5'd7, 5'd3,
                32'hDEADBEEF, 32'h0, 1'b0, 1'b0, 6'd0};
    tbl[2]  = '{2'b11, 5'd3, 5'd3, 32'h11, 32'h22, 1'b0, 5'd0, 5'd3, 5'd7,
                32'h22, 32'hDEADBEEF, 1'b0, 1'b0, 6'd0};
    tbl[3]  = '{2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 1'b0, 5'd0, 5'd3, 5'd9,
                32'h22, 32'h0, 1'b0, 1'b0, 6'd0};
    tbl[4]  = '{2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 1'b1, 5'd9, 5'd9, 5'd3,
                32'h0, 32'h22, 1'b0, 1'b0, 6'd1};
    tbl[5]  = '{2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 1'b0, 5'd0, 5'd9, 5'd9,
                32'h0, 32'h0, 1'b1, 1'b1, 6'd1};
    tbl[6]  = '{2'b10, 5'd0, 5'd9, 32'h0, 32'h55, 1'b0, 5'd0, 5'd9, 5'd3,
                32'h55, 32'h22, 1'b0, 1'b0, 6'd0};
    tbl[7]  = '{2'b01, 5'd4, 5'd0, 32'hAB, 32'h0, 1'b1, 5'd4, 5'd4, 5'd9,
                32'hAB, 32'h55, 1'b0, 1'b0, 6'd1};
    tbl[8]  = '{2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 1'b1, 5'd4, 5'd4, 5'd0,
                32'hAB, 32'h0, 1'b1, 1'b0, 6'd1};
    tbl[9]  = '{2'b01, 5'd0, 5'd0, 32'hFFFFFFFF, 32'h0, 1'b1, 5'd0, 5'd0, 5'd4,
                32'h0, 32'hAB, 1'b0, 1'b1, 6'd1};
    tbl[10] = '{2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 1'b0, 5'd0, 5'd4, 5'd9,
                32'hAB, 32'h55, 1'b1, 1'b0, 6'd1};

    // Reset state
    repeat (2) @(posedge clock);
    @(negedge clock);
    chk("reset rd_data0", rd_data[31:0], 32'h0);
    chk("reset rd_data1", rd_data[63:32], 32'h0);
    chk("reset stall", 32'(stall), 32'h0);
    chk("reset pending_cnt", 32'(pending_cnt), 32'h0);
    reset = 1'b0;

    for (int i = 0; i < 11; i++) begin
      do_cycle(tbl[i]);
      chk($sformatf("vec%0d rd_data0", i), a_d0, tbl[i].e_d0);
      chk($sformatf("vec%0d rd_data1", i), a_d1, tbl[i].e_d1);
      chk($sformatf("vec%0d rd_busy0", i), 32'(a_b0), 32'(tbl[i].e_b0));
      chk($sformatf("vec%0d rd_busy1", i), 32'(a_b1), 32'(tbl[i].e_b1));
      chk($sformatf("vec%0d stall", i), 32'(a_stall), 32'(tbl[i].e_b0 | tbl[i].e_b1));
      chk($sformatf("vec%0d pending_cnt", i), 32'(a_cnt), 32'(tbl[i].e_cnt));
    end

    // Reset asserted in the same cycle as a write to r5 (r4 is pending here)
    wr_en = 2'b01; wr_addr = {5'd0, 5'd5}; wr_data = {32'h0, 32'h1234};
    rsv_en = 1'b1; rsv_addr = 5'd6;
    rd_addr = {5'd4, 5'd5};
    reset = 1'b1;
    #2;
    chk("rst_mid rd_data0", rd_data[31:0], 32'h0);
    chk("rst_mid rd_busy1", 32'(rd_busy[1]), 32'h0);
    chk("rst_mid pending_cnt", 32'(pending_cnt), 32'h0);
    @(posedge clock);
    #1;
    @(negedge clock);
    reset = 1'b0;
    wr_en = '0; rsv_en = 1'b0;
    m_reset();
    #2;
    chk("rst_after r5", rd_data[31:0], 32'h0);
    chk("rst_after r4", rd_data[63:32], 32'h0);
    chk("rst_after pending_cnt", 32'(pending_cnt), 32'h0);
    @(negedge clock);

    // Random traffic on a narrow index range to force collisions
    for (int n = 0; n < 1500; n++) begin
      rv.wen = 2'($urandom_range(0, 3));
      rv.wa0 = 5'($urandom_range(0, 11));
      rv.wa1 = 5'($urandom_range(0, 11));
      rv.wd0 = $urandom;
      rv.wd1 = $urandom;
      rv.rsv = ($urandom_range(0, 2) == 0);
      rv.ra  = 5'($urandom_range(0, 11));
      rv.r0  = 5'($urandom_range(0, 11));
      rv.r1  = 5'($urandom_range(0, 31));
      do_cycle(rv);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
